// File: rtl/load_align_extend_if.sv
// ============================================================================
// load_align_extend_if : request / memory-beat / result handshakes for the
//                        memory-stage load formatter.  Revision: 1.0
// ============================================================================
`default_nettype none

interface load_align_extend_if #(
  parameter int DATA_W = 32
) ();
  localparam int OW = $clog2(DATA_W / 8);

  logic              req_valid;
  logic              req_ready;
  logic [OW-1:0]     req_offset;
  logic [1:0]        req_size;
  logic              req_signed;
  logic              mem_valid;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_data;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic              res_error;

  modport slave (
    input  req_valid, req_offset, req_size, req_signed,
    input  mem_valid, mem_data, res_ready,
    output req_ready, mem_ready, res_valid, res_data, res_error
  );

  modport master (
    output req_valid, req_offset, req_size, req_signed,
    output mem_valid, mem_data, res_ready,
    input  req_ready, mem_ready, res_valid, res_data, res_error
  );
endinterface

`default_nettype wire

// File: rtl/load_align_extend.sv
// ============================================================================
// load_align_extend : extracts, merges (across two beats) and sign/zero
//                     extends little-endian load data.  Revision: 1.0
// ============================================================================
`default_nettype none

module load_align_extend #(
  parameter int DATA_W           = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  load_align_extend_if.slave bus
);
  localparam int              NB   = DATA_W / 8;
  localparam int              OW   = $clog2(NB);
  localparam int              SW   = OW + 2;
  localparam logic [OW:0]     NB_L = (OW + 1)'(NB);
  localparam logic [SW-1:0]   NB_S = SW'(NB);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_LO = 2'd1,
    S_WAIT_HI = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t            state_q;
  logic [OW-1:0]     off_q;
  logic [1:0]        size_q;
  logic              sgn_q;
  logic [DATA_W-1:0] buf_q;
  logic [DATA_W-1:0] res_data_q;
  logic              res_error_q;

  logic [SW-1:0]     w_req_nbytes;
  logic              w_illegal;
  logic [SW-1:0]     w_nbytes;
  logic [SW-1:0]     w_end;
  logic              w_straddle;
  logic [OW+3:0]     w_hi_sh;
  logic [DATA_W-1:0] w_lo;
  logic [DATA_W-1:0] w_hi;
  logic [DATA_W-1:0] w_ext_lo;
  logic [DATA_W-1:0] w_ext_hi;

  // Bits at and above 8*nbytes are replaced by the fill, so stray bytes
  // beyond the access never need masking upstream.
  function automatic logic [DATA_W-1:0] ext_f(input logic [DATA_W-1:0] v,
                                               input logic [1:0]        sz,
                                               input logic              sg);
    logic [DATA_W-1:0] r;
    int                nbits;
    logic              fill;
    nbits = 8 << sz;
    if (nbits > DATA_W) nbits = DATA_W;
    fill = sg & v[nbits-1];
    for (int i = 0; i < DATA_W; i++) r[i] = (i < nbits) ? v[i] : fill;
    return r;
  endfunction

  assign w_req_nbytes = SW'(1) << bus.req_size;
  assign w_illegal    = (w_req_nbytes > NB_S);
  assign w_nbytes     = SW'(1) << size_q;
  assign w_end        = {2'b00, off_q} + w_nbytes;
  assign w_straddle   = (w_end > NB_S);

  // Low beat supplies bytes offset..NB-1 at the bottom; the high beat's
  // bytes land directly above them.
  assign w_hi_sh  = {NB_L - {1'b0, off_q}, 3'b000};
  assign w_lo     = bus.mem_data >> {off_q, 3'b000};
  assign w_hi     = bus.mem_data << w_hi_sh;
  assign w_ext_lo = ext_f(w_lo, size_q, sgn_q);
  assign w_ext_hi = ext_f(buf_q | w_hi, size_q, sgn_q);

  assign bus.req_ready = (state_q == S_IDLE) && !reset;
  assign bus.mem_ready = ((state_q == S_WAIT_LO) || (state_q == S_WAIT_HI)) && !reset;
  assign bus.res_valid = (state_q == S_RESP);
  assign bus.res_data  = res_data_q;
  assign bus.res_error = res_error_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      off_q       <= '0;
      size_q      <= '0;
      sgn_q       <= 1'b0;
      buf_q       <= '0;
      res_data_q  <= '0;
      res_error_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            off_q  <= bus.req_offset;
            size_q <= bus.req_size;
            sgn_q  <= bus.req_signed;
            if (w_illegal) begin
              res_data_q  <= '0;
              res_error_q <= 1'b1;
              state_q     <= S_RESP;
            end else begin
              state_q <= S_WAIT_LO;
            end
          end
        end
        S_WAIT_LO: begin
          if (bus.mem_valid) begin
            if (!w_straddle) begin
              res_data_q  <= w_ext_lo;
              res_error_q <= 1'b0;
              state_q     <= S_RESP;
            end else if (ALLOW_MISALIGNED) begin
              buf_q   <= w_lo;
              state_q <= S_WAIT_HI;
            end else begin
              res_data_q  <= '0;
              res_error_q <= 1'b1;
              state_q     <= S_RESP;
            end
          end
        end
        S_WAIT_HI: begin
          if (bus.mem_valid) begin
            res_data_q  <= w_ext_hi;
            res_error_q <= 1'b0;
            state_q     <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.res_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_load_align_extend.sv
// ============================================================================
// tb_load_align_extend : three instances (32b misaligned-ok, 32b strict, 64b)
//                        checked against a byte-array reference model.
// ============================================================================
`default_nettype none

module tb_load_align_extend;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int          sel   = 0;
  logic        drv_req_valid = 1'b0;
  logic [2:0]  drv_off = '0;
  logic [1:0]  drv_size = '0;
  logic        drv_sgn = 1'b0;
  logic        drv_mem_valid = 1'b0;
  logic [63:0] drv_mem_data = '0;
  logic        drv_res_ready = 1'b0;

  logic        o_req_ready, o_mem_ready, o_res_valid, o_res_error;
  logic [63:0] o_res_data;

  load_align_extend_if #(.DATA_W(32)) bm  ();
  load_align_extend_if #(.DATA_W(32)) ba  ();
  load_align_extend_if #(.DATA_W(64)) b64 ();

  load_align_extend #(.DATA_W(32), .ALLOW_MISALIGNED(1'b1)) u_m  (.clk(clk), .reset(reset), .bus(bm));
  load_align_extend #(.DATA_W(32), .ALLOW_MISALIGNED(1'b0)) u_a  (.clk(clk), .reset(reset), .bus(ba));
  load_align_extend #(.DATA_W(64), .ALLOW_MISALIGNED(1'b1)) u_64 (.clk(clk), .reset(reset), .bus(b64));

  assign bm.req_valid  = drv_req_valid && (sel == 0);
  assign bm.req_offset = drv_off[1:0];
  assign bm.req_size   = drv_size;
  assign bm.req_signed = drv_sgn;
  assign bm.mem_valid  = drv_mem_valid && (sel == 0);
  assign bm.mem_data   = drv_mem_data[31:0];
  assign bm.res_ready  = drv_res_ready && (sel == 0);

  assign ba.req_valid  = drv_req_valid && (sel == 1);
  assign ba.req_offset = drv_off[1:0];
  assign ba.req_size   = drv_size;
  assign ba.req_signed = drv_sgn;
  assign ba.mem_valid  = drv_mem_valid && (sel == 1);
  assign ba.mem_data   = drv_mem_data[31:0];
  assign ba.res_ready  = drv_res_ready && (sel == 1);

  assign b64.req_valid  = drv_req_valid && (sel == 2);
  assign b64.req_offset = drv_off;
  assign b64.req_size   = drv_size;
  assign b64.req_signed = drv_sgn;
  assign b64.mem_valid  = drv_mem_valid && (sel == 2);
  assign b64.mem_data   = drv_mem_data;
  assign b64.res_ready  = drv_res_ready && (sel == 2);

  always_comb begin
    o_req_ready = bm.req_ready;
    o_mem_ready = bm.mem_ready;
    o_res_valid = bm.res_valid;
    o_res_error = bm.res_error;
    o_res_data  = {32'd0, bm.res_data};
    if (sel == 1) begin
      o_req_ready = ba.req_ready;
      o_mem_ready = ba.mem_ready;
      o_res_valid = ba.res_valid;
      o_res_error = ba.res_error;
      o_res_data  = {32'd0, ba.res_data};
    end else if (sel == 2) begin
      o_req_ready = b64.req_ready;
      o_mem_ready = b64.mem_ready;
      o_res_valid = b64.res_valid;
      o_res_error = b64.res_error;
      o_res_data  = b64.res_data;
    end
  end

  // Reference: lay both beats out as one byte stream, pick nbytes from the
  // offset, then extend arithmetically.
  function automatic logic [63:0] model(input int dw, input int off, input int sz,
                                        input int sg, input logic [63:0] b0,
                                        input logic [63:0] b1);
    logic [7:0]  mb [16];
    logic [63:0] v;
    int          nb, n;
    nb = dw / 8;
    n  = 1 << sz;
    v  = '0;
    for (int i = 0; i < 16; i++) mb[i] = '0;
    for (int i = 0; i < nb; i++) begin
      mb[i]      = b0[8*i +: 8];
      mb[nb + i] = b1[8*i +: 8];
    end
    for (int k = 0; k < n; k++) v = v + (64'(mb[off + k]) << (8 * k));
    if ((sg != 0) && (n < nb) && v[8*n-1]) v = v - (64'd1 << (8 * n));
    if (dw == 32) v = v & 64'h0000_0000_FFFF_FFFF;
    return v;
  endfunction

  task automatic xact(input int s, input int off, input int sz, input int sg,
                      input logic [63:0] b0, input logic [63:0] b1,
                      output logic [63:0] d, output logic e, output int beats,
                      output int lat, output bit to);
    int i;
    beats = 0; lat = 0; to = 1'b0; d = '0; e = 1'b0; sel = s;
    @(negedge clk);
    i = 0;
    while (!o_req_ready && i < 20) begin @(negedge clk); i++; end
    if (!o_req_ready) begin to = 1'b1; return; end
    drv_req_valid = 1'b1; drv_off = 3'(off); drv_size = 2'(sz); drv_sgn = sg[0];
    @(negedge clk);
    drv_req_valid = 1'b0;
    lat = 1;
    for (i = 0; i < 20 && !o_res_valid; i++) begin
      if (o_mem_ready) begin
        drv_mem_valid = 1'b1;
        drv_mem_data  = (beats == 0) ? b0 : b1;
        beats++;
        lat = 0;
      end else begin
        drv_mem_valid = 1'($urandom);
        drv_mem_data  = {$urandom, $urandom};
      end
      @(negedge clk);
      lat++;
    end
    drv_mem_valid = 1'b0;
    if (!o_res_valid) begin to = 1'b1; return; end
    d = o_res_data; e = o_res_error;
    drv_res_ready = 1'b1;
    @(negedge clk);
    drv_res_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      total++;
      if (o_req_ready !== 1'b0 || o_mem_ready !== 1'b0) begin
        bad++; $display("FAIL reset_ready sel=%0d got req=%b mem=%b want 0 0", s, o_req_ready, o_mem_ready);
      end
    end
    reset = 1'b0; #1;
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      total++;
      if (o_res_valid !== 1'b0 || o_res_data !== 64'd0 || o_res_error !== 1'b0 || o_req_ready !== 1'b1) begin
        bad++; $display("FAIL reset_state sel=%0d got v=%b d=%h e=%b rr=%b want 0 0 0 1",
                        s, o_res_valid, o_res_data, o_res_error, o_req_ready);
      end
    end
  endtask

  typedef struct {
    int s; int off; int sz; int sg;
    logic [63:0] b0; logic [63:0] b1; logic [63:0] exp; logic err; int beats;
  } vec_t;

  task automatic test_directed();
    vec_t        v [7];
    logic [63:0] d; logic e; int beats, lat; bit to;
    v[0] = '{0, 3, 0, 1, 64'h80123456, 64'h0, 64'hFFFFFF80, 1'b0, 1};
    v[1] = '{0, 3, 0, 0, 64'h80123456, 64'h0, 64'h00000080, 1'b0, 1};
    v[2] = '{0, 3, 1, 1, 64'hAB000000, 64'h000000CD, 64'hFFFFCDAB, 1'b0, 2};
    v[3] = '{0, 3, 1, 0, 64'hAB000000, 64'h000000CD, 64'h0000CDAB, 1'b0, 2};
    v[4] = '{1, 3, 1, 1, 64'hAB000000, 64'h000000CD, 64'h0, 1'b1, 1};
    v[5] = '{0, 0, 3, 1, 64'h12345678, 64'h0, 64'h0, 1'b1, 0};
    v[6] = '{2, 4, 3, 1, 64'h89ABCDEF_00000000, 64'h00000000_01234567, 64'h0123456789ABCDEF, 1'b0, 2};
    for (int k = 0; k < 7; k++) begin
      xact(v[k].s, v[k].off, v[k].sz, v[k].sg, v[k].b0, v[k].b1, d, e, beats, lat, to);
      total++;
      if (to || d !== v[k].exp || e !== v[k].err) begin
        bad++; $display("FAIL directed_%0d got d=%h e=%b to=%b want d=%h e=%b", k, d, e, to, v[k].exp, v[k].err);
      end
      total++;
      if (beats != v[k].beats || lat != 1) begin
        bad++; $display("FAIL directed_beats_%0d got beats=%0d lat=%0d want beats=%0d lat=1", k, beats, lat, v[k].beats);
      end
    end
  endtask

  task automatic test_backpressure();
    sel = 0;
    @(negedge clk);
    drv_req_valid = 1'b1; drv_off = 3'd0; drv_size = 2'd2; drv_sgn = 1'b1;
    @(negedge clk);
    drv_req_valid = 1'b0;
    total++;
    if (o_mem_ready !== 1'b1) begin bad++; $display("FAIL bp_mem_ready got %b want 1", o_mem_ready); end
    drv_mem_valid = 1'b1; drv_mem_data = 64'h12345678;
    @(negedge clk);
    drv_mem_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      total++;
      if (o_res_valid !== 1'b1 || o_res_data !== 64'h12345678 || o_req_ready !== 1'b0 || o_mem_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold_%0d got v=%b d=%h rr=%b mr=%b want 1 12345678 0 0",
                        c, o_res_valid, o_res_data, o_req_ready, o_mem_ready);
      end
      @(negedge clk);
    end
    drv_res_ready = 1'b1;
    @(negedge clk);
    drv_res_ready = 1'b0;
    total++;
    if (o_res_valid !== 1'b0 || o_req_ready !== 1'b1) begin
      bad++; $display("FAIL bp_release got v=%b rr=%b want 0 1", o_res_valid, o_req_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] d; logic e; int beats, lat; bit to;
    sel = 0;
    @(negedge clk);
    drv_req_valid = 1'b1; drv_off = 3'd3; drv_size = 2'd1; drv_sgn = 1'b1;
    @(negedge clk);
    drv_req_valid = 1'b0;
    drv_mem_valid = 1'b1; drv_mem_data = 64'hAB000000;
    @(negedge clk);
    drv_mem_valid = 1'b0;
    total++;
    if (o_mem_ready !== 1'b1 || o_res_valid !== 1'b0) begin
      bad++; $display("FAIL mid_wait_hi got mr=%b v=%b want 1 0", o_mem_ready, o_res_valid);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; #1;
    total++;
    if (o_req_ready !== 1'b1 || o_res_valid !== 1'b0 || o_mem_ready !== 1'b0) begin
      bad++; $display("FAIL mid_reset_idle got rr=%b v=%b mr=%b want 1 0 0", o_req_ready, o_res_valid, o_mem_ready);
    end
    xact(0, 0, 0, 1, 64'h000000C5, 64'h0, d, e, beats, lat, to);
    total++;
    if (to || d !== 64'hFFFFFFC5 || e !== 1'b0 || beats != 1) begin
      bad++; $display("FAIL mid_after got d=%h e=%b beats=%0d to=%b want FFFFFFC5 0 1 0", d, e, beats, to);
    end
  endtask

  task automatic test_random();
    logic [63:0] d, b0, b1, exp; logic e, xe; int beats, lat, xb; bit to;
    int s, off, sz, sg, dw, n;
    bit illegal, strad;
    for (int k = 0; k < 80; k++) begin
      s   = int'($urandom_range(0, 2));
      dw  = (s == 2) ? 64 : 32;
      off = int'($urandom_range(0, dw / 8 - 1));
      sz  = int'($urandom_range(0, 3));
      sg  = int'($urandom_range(0, 1));
      b0  = {$urandom, $urandom};
      b1  = {$urandom, $urandom};
      n   = 1 << sz;
      illegal = (n > dw / 8);
      strad   = (off + n > dw / 8);
      xe  = illegal || (strad && s == 1);
      exp = xe ? 64'd0 : model(dw, off, sz, sg, b0, b1);
      xb  = illegal ? 0 : (strad ? ((s == 1) ? 1 : 2) : 1);
      xact(s, off, sz, sg, b0, b1, d, e, beats, lat, to);
      total++;
      if (to || d !== exp || e !== xe) begin
        bad++; $display("FAIL rand_%0d sel=%0d off=%0d sz=%0d sg=%0d got d=%h e=%b to=%b want d=%h e=%b",
                        k, s, off, sz, sg, d, e, to, exp, xe);
      end
      total++;
      if (beats != xb || lat != 1) begin
        bad++; $display("FAIL rand_beats_%0d got beats=%0d lat=%0d want beats=%0d lat=1", k, beats, lat, xb);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/load_align_extend.md
Name: load_align_extend

Overview:
- Memory-stage load formatter for the pipelined core, generalising the halfword sign/zero extender.
- Accepts a load descriptor (byte offset, size, signedness) and consumes one or two memory data beats, merging two beats when a misaligned access straddles a word boundary.
- Extracts the addressed bytes (little-endian), sign- or zero-extends them to DATA_W and presents the result to writeback over a valid/ready handshake.

Parameters:
- DATA_W, 32, datapath width in bits; legal values 32 or 64. NB = DATA_W/8 bytes per word, OW = log2(NB).
- ALLOW_MISALIGNED, 1, 1: straddling loads fetch a second beat and merge; 0: straddling loads return an error.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  load descriptor valid.
- req_ready  output  1  block can accept a descriptor.
- req_offset  input  OW  byte offset of the access within the first word.
- req_size  input  2  0 byte, 1 half, 2 word(32b), 3 dword(64b).
- req_signed  input  1  1 sign-extend, 0 zero-extend.
- mem_valid  input  1  memory data beat valid.
- mem_ready  output  1  block accepts a memory beat.
- mem_data  input  DATA_W  memory word, little-endian.
- res_valid  output  1  result valid.
- res_ready  input  1  writeback accepts the result.
- res_data  output  DATA_W  aligned, extended load value.
- res_error  output  1  misaligned (when disallowed) or illegal size.

Behaviour:
- Reset values:
  - state = IDLE; res_valid = 0; res_data = 0; res_error = 0; all internal byte buffers cleared.
  - req_ready and mem_ready are 0 while reset is high.
- Reset mid-operation:
  - Any in-flight access, including partial bytes captured in WAIT_HI, is discarded.
  - The FSM is in IDLE on the first cycle after reset deasserts.
- Access size: nbytes = 1 << req_size. The access is illegal if nbytes > NB (size 3 with DATA_W=32).
- Straddle condition: offset + nbytes > NB.
- FSM states: IDLE, WAIT_LO, WAIT_HI, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready, latch offset, size and signed.
  - Illegal size -> RESP with res_error = 1, res_data = 0. No memory beat is requested.
  - Otherwise -> WAIT_LO.
- WAIT_LO:
  - mem_ready = 1.
  - On mem_valid, capture bytes offset..min(offset+nbytes, NB)-1.
  - Not straddling -> RESP.
  - Straddling and ALLOW_MISALIGNED=1 -> WAIT_HI.
  - Straddling and ALLOW_MISALIGNED=0 -> RESP with res_error = 1, res_data = 0. mem_ready falls; no second beat is taken.
- WAIT_HI:
  - mem_ready = 1.
  - On mem_valid, capture the remaining (offset+nbytes-NB) bytes from byte 0 upward, appended above the low-beat bytes.
  - Then -> RESP.
- RESP:
  - res_valid = 1.
  - res_data and res_error are registered and held stable until res_ready.
  - On res_ready -> IDLE, res_valid = 0 the next cycle.
  - req_ready = 0 and mem_ready = 0 in this state.
- Extension:
  - The result MSB is bit 8*nbytes-1 of the merged value.
  - req_signed = 1: replicate the MSB into bits DATA_W-1..8*nbytes.
  - req_signed = 0: fill those bits with zeros.
  - Full-width loads are passed through unchanged.
- Latency:
  - res_valid rises 1 cycle after the final accepted memory beat.
  - res_valid rises 1 cycle after request acceptance for an illegal size.
- Throughput: one load in flight. Minimum 3 cycles per aligned load (accept, beat, respond) with res_ready high.
- mem_valid outside WAIT_LO/WAIT_HI is ignored, and is not consumed since mem_ready = 0.
- req_valid outside IDLE is ignored, since req_ready = 0.

Test Plan:
- DATA_W=32, byte at offset 3, signed, mem_data=0x80123456 -> res_data=0xFFFFFF80, res_error=0. Unsigned repeat -> 0x00000080.
- DATA_W=32, ALLOW_MISALIGNED=1, half at offset 3, signed, beats 0xAB000000 then 0x000000CD -> two beats accepted, res_data=0xFFFFCDAB. Unsigned -> 0x0000CDAB.
- DATA_W=32, ALLOW_MISALIGNED=0, same half-at-offset-3 request -> one beat accepted, mem_ready low afterwards, res_error=1, res_data=0.
- Word at offset 0, mem_data=0x12345678, res_ready held low 5 cycles -> res_valid=1 and res_data=0x12345678 stable throughout, req_ready=0. IDLE reached one cycle after res_ready.
- DATA_W=32, req_size=3 -> mem_ready never asserted, res_valid one cycle after acceptance with res_error=1. DATA_W=64 dword at offset 4 with beats 0x89ABCDEF_00000000 and 0x00000000_01234567 -> res_data=0x0123456789ABCDEF.
- Reset pulsed while in WAIT_HI -> next cycle state IDLE, res_valid=0, req_ready=1. A following aligned byte load returns a correct value with no stale bytes.
